// File: rtl/el2_pmp_chan_arb_pkg.sv
// Shared types for the PMP check-channel arbiter.
package el2_pmp_chan_arb_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    PMP_READ  = 2'd0,
    PMP_WRITE = 2'd1,
    PMP_EXEC  = 2'd2
  } el2_pmp_type_pkt_t;

endpackage

// File: rtl/el2_pmp_chan_arb.sv
// Round-robin arbiter sharing one combinational PMP check channel among NUM_REQ
// requesters; one check in flight, result returned two cycles after the grant.
module el2_pmp_chan_arb
  import el2_pmp_chan_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic              [NUM_REQ-1:0]       req_valid,
  output logic              [NUM_REQ-1:0]       req_ready,
  input  logic              [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  el2_pmp_type_pkt_t [NUM_REQ-1:0]       req_type,
  output logic              [NUM_REQ-1:0]       rsp_valid,
  output logic                                  rsp_err,
  input  logic                                  pmp_cfg_wr,
  input  logic                                  flush,
  output logic              [ADDR_W-1:0]        pmp_chan_addr,
  output el2_pmp_type_pkt_t                     pmp_chan_type,
  input  logic                                  pmp_chan_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CAND_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_owner;
  logic [ADDR_W-1:0] r_own_addr;
  el2_pmp_type_pkt_t r_own_type;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic              r_rsp_err;

  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_gnt_found;
  logic [CAND_W-1:0] w_cand;
  logic              w_grant_en;
  logic              w_hs;
  logic              w_chk_done;
  logic [IDX_W-1:0]  w_ptr_nxt;

  // Round-robin search starting at the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + CAND_W'(k);
      if (w_cand >= CAND_W'(NUM_REQ)) begin
        w_cand = w_cand - CAND_W'(NUM_REQ);
      end
      if (!w_gnt_found && req_valid[w_cand[IDX_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand[IDX_W-1:0];
      end
    end
  end

  // The channel is free to accept in IDLE and in RESP (back-to-back checks).
  assign w_grant_en = !rst && !flush && (r_state != CHECK) && w_gnt_found;
  assign w_hs       = w_grant_en;
  assign req_ready  = w_grant_en ? (NUM_REQ'(1) << w_gnt_idx) : '0;

  assign w_ptr_nxt = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + IDX_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A config write during CHECK invalidates the sample; flush beats it.
  always_comb begin
    w_state_nxt = r_state;
    w_chk_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (!pmp_cfg_wr) begin
          w_state_nxt = RESP;
          w_chk_done  = 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = w_hs ? CHECK : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_own_addr  <= '0;
      r_own_type  <= PMP_READ;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_chk_done ? (NUM_REQ'(1) << r_owner) : '0;
      if (w_chk_done) begin
        r_rsp_err <= pmp_chan_err;
      end
      if (w_hs) begin
        r_owner    <= w_gnt_idx;
        r_own_addr <= req_addr[w_gnt_idx];
        r_own_type <= req_type[w_gnt_idx];
        r_ptr      <= w_ptr_nxt;
      end
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_err       = r_rsp_err;
  assign pmp_chan_addr = r_own_addr;
  assign pmp_chan_type = r_own_type;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_grant_valid:  assert property (@(posedge clk) disable iff (rst) (req_ready & ~req_valid) == '0);

endmodule

// File: tb/tb_el2_pmp_chan_arb.sv
// Scoreboard bench: transaction-level model predicts grants and results,
// a separate monitor matches every rsp_valid pulse against the expected queue.
module tb_el2_pmp_chan_arb;
  import el2_pmp_chan_arb_pkg::*;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N-1:0][31:0] addr_q;
  el2_pmp_type_pkt_t [N-1:0] type_q;
  logic [N-1:0] rsp_valid;
  logic rsp_err;
  logic pmp_cfg_wr;
  logic flush;
  logic [31:0] pmp_chan_addr;
  el2_pmp_type_pkt_t pmp_chan_type;
  logic pmp_chan_err;

  el2_pmp_chan_arb #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (addr_q),
    .req_type     (type_q),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .pmp_cfg_wr   (pmp_cfg_wr),
    .flush        (flush),
    .pmp_chan_addr(pmp_chan_addr),
    .pmp_chan_type(pmp_chan_type),
    .pmp_chan_err (pmp_chan_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Toy PMP: each committed config write flips the fault polarity.
  logic [3:0] gen = 4'd0;
  always @(posedge clk) if (pmp_cfg_wr) gen <= gen + 4'd1;

  function automatic logic policy(input logic [31:0] a, input el2_pmp_type_pkt_t t, input logic [3:0] g);
    return a[8] ^ (t == PMP_EXEC) ^ g[0];
  endfunction

  assign pmp_chan_err = policy(pmp_chan_addr, pmp_chan_type, gen);

  typedef struct {
    int   due;
    int   owner;
    logic err;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  bit m_known = 1'b0;
  bit m_busy  = 1'b0;
  int m_ptr   = 0;
  int m_owner = 0;
  logic [31:0] m_addr = '0;
  el2_pmp_type_pkt_t m_type = PMP_READ;
  logic m_err = 1'b0;
  int pend_g = -1;
  bit rand_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus: drive, predict, compare, then advance the model.
  task automatic step(input logic i_rst, input logic [N-1:0] v, input logic fl, input logic cw);
    logic [N-1:0] exp_rdy;
    int g;
    logic e;
    if (rand_mode && pend_g >= 0) begin
      addr_q[pend_g] = $urandom;
      type_q[pend_g] = el2_pmp_type_pkt_t'(2'($urandom_range(0, 2)));
      pend_g = -1;
    end
    rst = i_rst; req_valid = v; flush = fl; pmp_cfg_wr = cw;
    #1;
    exp_rdy = '0;
    g = -1;
    if (!i_rst && !fl && !m_busy) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && v[j]) g = j;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (m_known) begin
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("chan_addr", 64'(pmp_chan_addr), 64'(m_addr));
      chk("chan_type", 64'(pmp_chan_type), 64'(m_type));
      chk("rsp_err_hold", 64'(rsp_err), 64'(m_err));
    end
    if (i_rst) begin
      m_busy = 1'b0; m_ptr = 0; m_owner = 0;
      m_addr = '0; m_type = PMP_READ; m_err = 1'b0; m_known = 1'b1;
    end else begin
      if (m_busy && fl) begin
        m_busy = 1'b0;
      end else if (m_busy && !cw) begin
        e = policy(m_addr, m_type, gen);
        sb.push_back('{due: cyc + 1, owner: m_owner, err: e});
        m_err = e;
        m_busy = 1'b0;
      end
      if (g >= 0) begin
        m_busy = 1'b1; m_owner = g;
        m_addr = addr_q[g]; m_type = type_q[g];
        m_ptr = (g + 1) % N;
        pend_g = g;
      end
    end
    @(negedge clk);
  endtask

  // Response monitor: every pulse must match the oldest expected result.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #3;
      if (m_known) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          x = sb.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(N'(1) << x.owner));
          chk("rsp_err", 64'(rsp_err), 64'(x.err));
        end else if (rsp_valid != '0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected cyc=%0d got=%0h want=0", cyc, rsp_valid);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; flush = 1'b0; pmp_cfg_wr = 1'b0;
    for (int i = 0; i < N; i++) begin
      addr_q[i] = 32'h1000 * (i + 1);
      type_q[i] = PMP_READ;
    end

    step(1, '0, 0, 0); step(1, '0, 0, 0); step(0, '0, 0, 0);
    // All requesting continuously from reset: 0,1,2,0 every other cycle
    repeat (8) step(0, 3'b111, 0, 0);
    step(0, '0, 0, 0); step(0, '0, 0, 0);

    step(1, '0, 0, 0); step(0, '0, 0, 0);
    addr_q[0] = 32'h0000_1000; type_q[0] = PMP_READ;
    step(0, 3'b001, 0, 0); step(0, '0, 0, 0); step(0, '0, 0, 0); step(0, '0, 0, 0);

    // Config write in first CHECK cycle flips the result to a fault
    addr_q[1] = 32'h0000_3000; type_q[1] = PMP_READ;
    step(0, 3'b010, 0, 0); step(0, '0, 0, 1); step(0, '0, 0, 0); step(0, '0, 0, 0); step(0, '0, 0, 0);

    addr_q[2] = 32'h0000_2100; type_q[2] = PMP_EXEC;
    step(0, 3'b100, 0, 0); step(0, '0, 0, 0); step(0, '0, 0, 0); step(0, '0, 0, 0);

    // Flush in CHECK, then the next grant moves past the flushed owner
    step(0, 3'b001, 0, 0); step(0, '0, 1, 0); step(0, 3'b111, 0, 0);
    step(0, '0, 0, 0); step(0, '0, 0, 0); step(0, '0, 0, 0);

    // Reset mid-check, pointer back to 0
    step(0, 3'b111, 0, 0); step(1, '0, 0, 0); step(0, 3'b110, 0, 0);
    step(0, '0, 0, 0); step(0, '0, 0, 0); step(0, '0, 0, 0);

    rand_mode = 1'b1;
    repeat (800) begin
      step(($urandom % 64) == 0, N'($urandom), ($urandom % 16) == 0, ($urandom % 6) == 0);
    end
    repeat (6) step(0, '0, 0, 0);

    chk("sb_drain", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/el2_pmp_chan_arb.md
EL2_PMP_CHAN_ARB -- requirements
Module: el2_pmp_chan_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of requesters sharing one PMP check channel, legal range 2..8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, NUM_REQ bits: request pending, one bit per requester.
REQ-005 SHALL have port req_ready, output, NUM_REQ bits: grant; at most one bit set per cycle.
REQ-006 SHALL have port req_addr, input, NUM_REQ x 32 bits: byte address per requester.
REQ-007 SHALL have port req_type, input, NUM_REQ x el2_pmp_type_pkt_t: access type (READ/WRITE/EXEC) per requester.
REQ-008 SHALL have port rsp_valid, output, NUM_REQ bits: one-cycle result pulse to the owning requester.
REQ-009 SHALL have port rsp_err, output, 1 bit: PMP fault result; qualified by any rsp_valid bit.
REQ-010 SHALL have port pmp_cfg_wr, input, 1 bit: a pmpcfg/pmpaddr/mseccfg CSR write commits this cycle.
REQ-011 SHALL have port flush, input, 1 bit: cancel the in-flight check.
REQ-012 SHALL have port pmp_chan_addr, output, 32 bits: address driven to the PMP channel.
REQ-013 SHALL have port pmp_chan_type, output, el2_pmp_type_pkt_t: type driven to the PMP channel.
REQ-014 SHALL have port pmp_chan_err, input, 1 bit: combinational PMP result for pmp_chan_addr/pmp_chan_type.

Function
REQ-015 SHALL implement FSM states IDLE, CHECK and RESP.
REQ-016 SHALL, in IDLE or RESP with any req_valid set and flush low, assert req_ready for exactly one requester, chosen round-robin.
REQ-017 SHALL give round-robin priority to (last granted index + 1) mod NUM_REQ and then ascending with wrap; after reset the pointer is 0 (requester 0 highest).
REQ-018 SHALL, on a handshake (req_valid & req_ready), capture addr, type and requester index into owner registers and go to CHECK the next cycle.
REQ-019 SHALL drive pmp_chan_addr and pmp_chan_type from the owner registers; outside CHECK they hold their last values.
REQ-020 SHALL, in CHECK with pmp_cfg_wr low, register pmp_chan_err into rsp_err and go to RESP.
REQ-021 SHALL, in CHECK with pmp_cfg_wr high, discard the sample and stay in CHECK one more cycle, re-checking against the updated configuration; repeated pmp_cfg_wr extends CHECK without bound.
REQ-022 SHALL, in RESP, pulse rsp_valid[owner] for one cycle, then go to CHECK if a new handshake occurred that cycle, else to IDLE.
REQ-023 SHALL deliver rsp_valid in cycle T+2 for a handshake in cycle T when pmp_cfg_wr is not seen in CHECK; sustained throughput is one check per 2 cycles.
REQ-024 SHALL, on flush in CHECK, go to IDLE with no rsp_valid and no grant that cycle.
REQ-025 SHALL, on flush in RESP, still deliver the RESP pulse but grant nothing that cycle, then go to IDLE.
REQ-026 SHALL, on flush in IDLE, grant nothing that cycle.
REQ-027 SHALL advance the round-robin pointer only on a handshake.
REQ-028 SHALL assert req_ready only while req_valid of the same index is high; req_ready is combinational from state, req_valid and pointer.
REQ-029 SHALL hold rsp_err stable from RESP until the next RESP.

Reset
REQ-030 SHALL, while rst is high, force state IDLE, pointer 0, owner registers and pmp_chan_addr 0, pmp_chan_type READ, and rsp_valid, rsp_err and req_ready 0.
REQ-031 SHALL abort any in-flight check on reset mid-operation with no rsp_valid, and accept no handshake in the reset cycle.

Verification
REQ-032 SHALL cover: req_valid=3'b001, addr 0x1000, READ, pmp_chan_err=0 at T+1 -> req_ready[0] at T, pmp_chan_addr=0x1000 at T+1, rsp_valid=3'b001 with rsp_err=0 at T+2.
REQ-033 SHALL cover: req_valid=3'b111 held continuously -> grants in order 0,1,2,0 every 2 cycles, with each rsp_valid landing 2 cycles after its grant.
REQ-034 SHALL cover: pmp_cfg_wr=1 in the first CHECK cycle, pmp_chan_err 0 then 1 -> rsp_valid at T+3 with rsp_err=1.
REQ-035 SHALL cover: flush in the CHECK cycle -> no rsp_valid and state IDLE; the next grant goes to index+1 of the flushed owner.
REQ-036 SHALL cover: rst raised during CHECK -> cycle after: all outputs 0, and req_valid=3'b110 afterwards grants requester 1 first.
REQ-037 SHALL cover: EXEC request from requester 2 with pmp_chan_err=1 -> pmp_chan_type=EXEC during CHECK, rsp_valid=3'b100 with rsp_err=1.
